// File: rtl/inst_mem_pkg.sv
// inst_mem_sync shared types and constants
// fault codes, fetch FSM encoding, default NOP
package inst_mem_pkg;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_PARITY   = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_sync_if.sv
// inst_mem_sync fetch + program-load bundle
// master = fetch stage / loader, slave = memory
interface inst_mem_sync_if #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
);

  logic                  fetch_req;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  fetch_ready;
  logic                  stall;
  logic                  flush;
  logic [DATA_W-1:0]     inst;
  logic                  inst_valid;
  logic                  fault;
  logic [1:0]            fault_code;
  logic                  prog_we;
  logic [DEPTH_LOG2-1:0] prog_addr;
  logic [DATA_W-1:0]     prog_data;
  logic [CNT_W-1:0]      fetch_cnt;

  modport master (
    output fetch_req, fetch_addr, stall, flush,
    output prog_we, prog_addr, prog_data,
    input  fetch_ready, inst, inst_valid,
    input  fault, fault_code, fetch_cnt
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, flush,
    input  prog_we, prog_addr, prog_data,
    output fetch_ready, inst, inst_valid,
    output fault, fault_code, fetch_cnt
  );

endinterface

// File: rtl/inst_mem_array.sv
// inst_mem_sync storage: 1 write port, registered read
// INST_MEM_PARITY_EN adds an even-parity bit per word
module inst_mem_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  perr
);

`ifdef INST_MEM_PARITY_EN
  logic [DATA_W:0] mem [2**DEPTH_LOG2];

  // write word with its parity bit on top
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= {^wdata, wdata};
  end

  // registered read; odd total parity flags corruption
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr][DATA_W-1:0];
      perr  <= ^mem[raddr];
    end
  end
`else
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read; held while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

  assign perr = 1'b0;
`endif

endmodule

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: registered fetch memory for IF stage
// optional parity check via INST_MEM_PARITY_EN
module inst_mem_sync
  import inst_mem_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              DEPTH_LOG2 = 6,
  parameter int              ADDR_W     = 32,
  parameter int              CNT_W      = 16,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(NOP_DEFAULT)
) (
  input logic            clk,
  input logic            rst_n,
  inst_mem_sync_if.slave bus
);

  state_t           state;
  logic             fault_q;
  logic [1:0]       code_q;
  logic [CNT_W-1:0] cnt;
  logic             misal;
  logic             rng;
  logic [1:0]       code_d;
  logic             bad;
  logic             acc;
  logic             live;
  logic             perr;
  logic             perr_hit;
  logic [DATA_W-1:0] rdata;

  assign misal = |bus.fetch_addr[1:0];
  assign rng   = |(bus.fetch_addr >> (DEPTH_LOG2 + 2));

  assign bus.fetch_ready = !bus.stall && !bus.prog_we
                         && rst_n;
  assign acc = bus.fetch_req && bus.fetch_ready
             && !bus.flush;

  // fault decode, misalignment wins over range
  always_comb begin
    code_d = FC_NONE;
    unique case (1'b1)
      misal:          code_d = FC_MISALIGN;
      (!misal && rng): code_d = FC_RANGE;
      default:        code_d = FC_NONE;
    endcase
  end

  assign bad = (code_d != FC_NONE);

  inst_mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (bus.prog_we && rst_n),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (acc && !bad),
    .raddr (bus.fetch_addr[DEPTH_LOG2+1:2]),
    .rdata (rdata),
    .perr  (perr)
  );

  // fetch FSM, fault status and saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      cnt     <= '0;
    end else begin
      if (acc && cnt != '1) cnt <= cnt + 1'b1;
      if (bus.flush) begin
        state   <= EMPTY;
        fault_q <= 1'b0;
        code_q  <= FC_NONE;
      end else if (acc) begin
        state   <= VALID;
        fault_q <= bad;
        code_q  <= code_d;
      end else if (!bus.stall) begin
        state   <= EMPTY;
        fault_q <= 1'b0;
        code_q  <= FC_NONE;
      end
    end
  end

  assign live     = (state == VALID);
  assign perr_hit = live && !fault_q && perr;

  assign bus.inst_valid = live;
  assign bus.fault      = fault_q || perr_hit;
  assign bus.fault_code = perr_hit ? FC_PARITY : code_q;
  assign bus.inst       = (live && !fault_q && !perr_hit)
                        ? rdata : NOP_WORD;
  assign bus.fetch_cnt  = cnt;

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb_inst_mem_sync: directed plan + random stimulus
// checked every cycle against a behavioural model
module tb_inst_mem_sync;

  localparam int CW  = 8;
  localparam int SAT = 255;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  inst_mem_sync_if #(.CNT_W(CW)) bus ();

  inst_mem_sync #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural model
  logic [31:0] mem [64];
  logic [31:0] m_inst  = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;
  logic [1:0]  m_code  = 2'b00;
  int          m_cnt   = 0;

  wire m_acc = bus.fetch_req && !bus.stall
             && !bus.prog_we && !bus.flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inst  <= 32'h0;
      m_valid <= 1'b0;
      m_fault <= 1'b0;
      m_code  <= 2'b00;
      m_cnt   <= 0;
    end else begin
      if (bus.prog_we)
        mem[int'(bus.prog_addr)] <= bus.prog_data;
      if (m_acc)
        m_cnt <= (m_cnt >= SAT) ? SAT : m_cnt + 1;
      if (bus.flush) begin
        m_valid <= 1'b0;
        m_inst  <= 32'h0;
        m_fault <= 1'b0;
        m_code  <= 2'b00;
      end else if (m_acc) begin
        m_valid <= 1'b1;
        if (bus.fetch_addr % 4 != 0) begin
          m_inst  <= 32'h0;
          m_fault <= 1'b1;
          m_code  <= 2'b01;
        end else if (bus.fetch_addr >= 32'd256) begin
          m_inst  <= 32'h0;
          m_fault <= 1'b1;
          m_code  <= 2'b10;
        end else begin
          m_inst  <= mem[bus.fetch_addr / 4];
          m_fault <= 1'b0;
          m_code  <= 2'b00;
        end
      end else if (!bus.stall) begin
        m_valid <= 1'b0;
        m_inst  <= 32'h0;
        m_fault <= 1'b0;
        m_code  <= 2'b00;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("c_inst",  bus.inst, m_inst);
    chk("c_valid", 32'(bus.inst_valid), 32'(m_valid));
    chk("c_fault", 32'(bus.fault), 32'(m_fault));
    chk("c_code",  32'(bus.fault_code), 32'(m_code));
    chk("c_cnt",   32'(bus.fetch_cnt), m_cnt);
    chk("c_ready", 32'(bus.fetch_ready),
        32'(!bus.stall && !bus.prog_we && rst_n));
  end

  task automatic setin(input logic req,
                       input logic [31:0] a,
                       input logic st,
                       input logic fl,
                       input logic we,
                       input logic [5:0] wa,
                       input logic [31:0] wd);
    bus.fetch_req  = req;
    bus.fetch_addr = a;
    bus.stall      = st;
    bus.flush      = fl;
    bus.prog_we    = we;
    bus.prog_addr  = wa;
    bus.prog_data  = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    setin(1'b1, a, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    int k;
    rst_n = 1'b0;
    setin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    repeat (2) tick();
    chk("rst_inst",  bus.inst, 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_cnt",   32'(bus.fetch_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // load all 64 words
    for (int i = 0; i < 64; i++) begin
      w = 32'hA000_0000 | i;
      if (i == 0) w = 32'h0010_0443;
      if (i == 1) w = 32'h0020_1025;
      setin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'(i), w);
      tick();
    end

    fetch(32'h0);
    chk("ld_w0", bus.inst, 32'h0010_0443);
    chk("ld_v0", 32'(bus.inst_valid), 32'h1);
    fetch(32'h4);
    chk("ld_w1", bus.inst, 32'h0020_1025);
    chk("ld_cnt", 32'(bus.fetch_cnt), 32'd2);

    // stall holds the word-1 response
    for (int i = 0; i < 3; i++) begin
      setin(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      chk("st_ready", 32'(bus.fetch_ready), 32'h0);
      tick();
      chk("st_inst", bus.inst, 32'h0020_1025);
      chk("st_cnt", 32'(bus.fetch_cnt), 32'd2);
    end
    fetch(32'h8);
    chk("st_w2", bus.inst, 32'hA000_0002);

    // flush beats stall and request
    setin(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 6'd0, 32'h0);
    tick();
    chk("fl_valid", 32'(bus.inst_valid), 32'h0);
    chk("fl_inst", bus.inst, 32'h0);
    chk("fl_cnt", 32'(bus.fetch_cnt), 32'd3);

    // faults
    fetch(32'h6);
    chk("f_mis", 32'(bus.fault_code), 32'h1);
    chk("f_mis_inst", bus.inst, 32'h0);
    chk("f_mis_flt", 32'(bus.fault), 32'h1);
    fetch(32'h100);
    chk("f_rng", 32'(bus.fault_code), 32'h2);
    chk("f_cnt", 32'(bus.fetch_cnt), 32'd5);

    // write/fetch conflict
    setin(1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 6'd3, 32'hDEAD_BEEF);
    #1;
    chk("wc_ready", 32'(bus.fetch_ready), 32'h0);
    tick();
    chk("wc_valid", 32'(bus.inst_valid), 32'h0);
    fetch(32'hC);
    chk("wc_new", bus.inst, 32'hDEAD_BEEF);
    chk("wc_cnt", 32'(bus.fetch_cnt), 32'd6);

    // async reset while VALID
    fetch(32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_inst", bus.inst, 32'h0);
    chk("ar_valid", 32'(bus.inst_valid), 32'h0);
    chk("ar_cnt", 32'(bus.fetch_cnt), 32'h0);
    setin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0, 32'h1234_5678);
    tick();
    rst_n = 1'b1;
    fetch(32'h0);
    chk("ar_keep", bus.inst, 32'h0010_0443);
    chk("ar_cnt1", 32'(bus.fetch_cnt), 32'd1);

    // random traffic
    repeat (1200) begin
      k = $urandom_range(0, 19);
      if (k < 14)
        a = 32'($urandom_range(0, 63)) * 4;
      else if (k < 17)
        a = 32'($urandom_range(0, 255));
      else
        a = $urandom | (32'h1 << $urandom_range(8, 31));
      setin($urandom_range(0, 9) < 7, a,
            $urandom_range(0, 19) < 3,
            $urandom_range(0, 9) < 1,
            $urandom_range(0, 9) < 1,
            6'($urandom_range(0, 63)), $urandom);
      tick();
    end
    chk("sat", 32'(bus.fetch_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
Parametrised synchronous instruction memory for the pipelined CPU fetch stage; successor to the fixed 64-word combinational ROM.
- Storage is writable through a program-load port, so test programs are loaded at run time rather than hard-coded.
- Read is registered (1-cycle latency) and supports stall, flush, alignment/range fault reporting and a saturating fetch counter.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
DATA_W, 32, instruction word width
DEPTH_LOG2, 6, log2 of word count (default 64 words)
ADDR_W, 32, byte-address (PC) width
CNT_W, 16, fetch counter width
NOP_WORD, 32'h00000000, word driven on flush/fault/empty

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_req  in  1  fetch request this cycle
fetch_addr  in  ADDR_W  byte address (PC)
fetch_ready  out  1  request can be accepted this cycle
stall  in  1  hold current output, accept nothing
flush  in  1  discard output/pending fetch
inst  out  DATA_W  fetched instruction
inst_valid  out  1  inst holds a response
fault  out  1  response is a fault (inst = NOP_WORD)
fault_code  out  2  00 none, 01 misaligned, 10 out of range
prog_we  in  1  program-load write strobe
prog_addr  in  DEPTH_LOG2  word index to write
prog_data  in  DATA_W  word to write
fetch_cnt  out  CNT_W  count of accepted fetches, saturating

Behaviour:
- Reset (rst_n low, async): inst=NOP_WORD, inst_valid=0, fault=0, fault_code=00, fetch_cnt=0, FSM=EMPTY. Memory contents are not reset and survive reset.
- Word index = fetch_addr[DEPTH_LOG2+1:2].
- fetch_ready = !stall && !prog_we && rst_n. Accept = fetch_req && fetch_ready && !flush.
- Latency: a request accepted in cycle N gives its response in cycle N+1 (inst_valid=1).
- Faults, checked in this priority order:
  - fetch_addr[1:0]!=0 gives code 01.
  - Any fetch_addr bit above DEPTH_LOG2+1 set gives code 10.
  - On a fault, the response is inst=NOP_WORD, fault=1, inst_valid=1, and the memory is not read.
- FSM states EMPTY and VALID:
  - EMPTY→VALID on accept.
  - VALID→VALID on accept.
  - VALID→EMPTY when no accept and no stall.
  - Any state→EMPTY on flush.
- Stall: inst, inst_valid, fault and fault_code hold their values; no new accept. Flush overrides stall.
- Flush: next cycle inst_valid=0, inst=NOP_WORD, fault=0. Flush overrides a same-cycle fetch_req.
- In EMPTY: inst=NOP_WORD, fault=0.
- Program write: prog_we writes prog_data at prog_addr on the rising edge, and fetch_ready is low that cycle, so read-during-write cannot occur. A response already in VALID is unaffected. A fetch of that word after the write returns the new data.
- fetch_cnt increments on each accept, faults included, and saturates at all-ones.
- prog_we during reset is ignored.

Optional Feature:
INST_MEM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on write and checked on read.
  - A mismatch gives inst=NOP_WORD, fault=1 and fault_code=11.
  - The parity bit is not resettable.
- Undefined: no parity storage; code 11 never occurs.

Decomposition:
- Package inst_mem_pkg holds:
  - fault_code constants FC_NONE, FC_MISALIGN, FC_RANGE, FC_PARITY;
  - FSM state encoding EMPTY/VALID;
  - default NOP_WORD.
- One sub-module, inst_mem_array: DEPTH×DATA_W (+1 parity bit when enabled) storage with a single write port and a registered read port.
- The top level holds the FSM, fault decode, stall/flush control and counter.

Test Plan:
- Load and read: write words 0..7 via prog_we (word 0 = 32'h00100443, word 1 = 32'h00201025), then fetch addr 0x0 and 0x4 back-to-back → inst = 32'h00100443 in cycle N+1 and 32'h00201025 in cycle N+2, inst_valid=1 both cycles, fetch_cnt=2.
- Stall: fetch 0x4, assert stall 3 cycles with fetch_req=1 at 0x8 → inst holds 32'h00201025 for all 3 cycles, fetch_ready=0, fetch_cnt unchanged; after release, 0x8 returns word 2.
- Flush priority: flush=1, stall=1 and fetch_req=1 in the same cycle → next cycle inst_valid=0, inst=32'h0, FSM=EMPTY, fetch_cnt unchanged.
- Faults:
  - fetch 0x6 → fault=1, fault_code=01, inst=32'h0.
  - fetch 0x100 (DEPTH_LOG2=6) → fault_code=10.
  - fetch_cnt counts both.
- Write/fetch conflict: prog_we=1 to word 3 with fetch_req at 0xC in the same cycle → fetch_ready=0, no response; refetch returns the new word.
- Reset mid-operation: deassert rst_n asynchronously while VALID → outputs zero immediately; after release, refetch 0x0 returns the previously loaded 32'h00100443.
